// File: rtl/hex_display_pkg.sv
// Shared constants and types for the 8-digit hexadecimal seven-segment display.
package hex_display_pkg;

  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned SEG_W      = 7;

  // Active-low abcdefg codes; bit 6 = a ... bit 0 = g.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06,
    7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60,
    7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef logic [2:0] digit_idx_t;

endpackage

// File: rtl/seg7_decoder.sv
// Hex nibble to active-low seven-segment code, purely combinational.
module seg7_decoder
  import hex_display_pkg::*;
(
  input  logic [3:0]       nibble,
  output logic [SEG_W-1:0] a_to_g
);

  // Table lookup of the segment pattern for the nibble.
  always_comb begin
    a_to_g = SEG_TABLE[nibble];
  end

endmodule

// File: rtl/hex_display_top.sv
// Free-running 32-bit counter shown in hex on an 8-digit multiplexed
// common-anode seven-segment display.
module hex_display_top
  import hex_display_pkg::*;
#(
  parameter int unsigned REFRESH_BITS = 2,
  parameter int unsigned TICK_BITS    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic [NUM_DIGITS-1:0] an,
  output logic [SEG_W-1:0]      a_to_g
);

  localparam int unsigned CNT_W = REFRESH_BITS + 3;

  logic [CNT_W-1:0]     refresh_cnt;
  logic [TICK_BITS-1:0] prescaler;
  logic [31:0]          value;
  digit_idx_t           idx;
  logic [3:0]           nibble;

  // Scan counter, tick prescaler and displayed value; async active-low clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      refresh_cnt <= '0;
      prescaler   <= '0;
      value       <= '0;
    end else begin
      refresh_cnt <= refresh_cnt + CNT_W'(1);
      prescaler   <= prescaler + TICK_BITS'(1);
      if (prescaler == '1) begin
        value <= value + 32'd1;
      end
    end
  end

  // Digit select from the top three scan bits; drive its anode and nibble.
  always_comb begin
    idx    = refresh_cnt[CNT_W-1 -: 3];
    an     = ~(NUM_DIGITS'(1) << idx);
    nibble = value[{idx, 2'b00} +: 4];
  end

  seg7_decoder u_seg7_decoder (
    .nibble (nibble),
    .a_to_g (a_to_g)
  );

endmodule

// File: tb/tb_hex_display_top.sv
// Self-checking bench for hex_display_top with an arithmetic reference model.
module tb_hex_display_top;

  localparam int unsigned RB = 2;
  localparam int unsigned TK = 4;

  localparam logic [6:0] REF_SEG [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  logic       clk;
  logic       rst;
  logic [7:0] an;
  logic [6:0] a_to_g;
  logic [3:0] dec_in;
  logic [6:0] dec_out;

  int n_cmp;
  int n_err;
  longint t;       // rising edges since reset release
  bit     run_cmp;

  hex_display_top #(.REFRESH_BITS(RB), .TICK_BITS(TK)) dut (
    .clk    (clk),
    .rst    (rst),
    .an     (an),
    .a_to_g (a_to_g)
  );

  seg7_decoder u_dec (
    .nibble (dec_in),
    .a_to_g (dec_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t (t=%0d)", name, act, exp, $time, t);
    end
  endtask

  function automatic logic [7:0] exp_an(input longint tt);
    int unsigned d;
    d = int'((tt / (64'd1 << RB)) % 8);
    return ~(8'd1 << d);
  endfunction

  function automatic logic [6:0] exp_seg(input longint tt);
    int unsigned d;
    longint      v;
    int unsigned nib;
    d   = int'((tt / (64'd1 << RB)) % 8);
    v   = (tt / (64'd1 << TK)) % (64'd1 << 32);
    nib = int'((v / (64'd1 << (4 * d))) % 16);
    return REF_SEG[nib];
  endfunction

  // Reference edge count: cleared while reset is low, counts edges otherwise.
  initial begin
    t = 0;
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) t = 0;
      else if (clk) t++;
    end
  end

  // Per-cycle comparison against the model on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (run_cmp) begin
        check("an", {24'd0, an}, {24'd0, exp_an(t)});
        check("a_to_g", {25'd0, a_to_g}, {25'd0, exp_seg(t)});
        check("an_one_zero", $countones(~an), 1);
      end
    end
  end

  task automatic pin(input string name, input logic [7:0] e_an, input logic [6:0] e_seg);
    check({name, "_an"}, {24'd0, an}, {24'd0, e_an});
    check({name, "_seg"}, {25'd0, a_to_g}, {25'd0, e_seg});
  endtask

  task automatic run_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp   = 0;
    n_err   = 0;
    run_cmp = 1'b0;
    rst     = 1'b0;
    dec_in  = '0;

    // Decoder sweep
    for (int unsigned i = 0; i < 16; i++) begin
      dec_in = 4'(i);
      #1;
      check($sformatf("dec_%0h", i), {25'd0, dec_out}, {25'd0, REF_SEG[i]});
    end

    run_cmp = 1'b1;
    // Held in reset for 4 cycles
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      pin("in_reset", 8'hFE, 7'h01);
    end
    #1 rst = 1'b1;

    // Scan and count pins from the first release
    for (int i = 1; i <= 64; i++) begin
      run_edges(1);
      case (i)
        4:  pin("t4", 8'hFD, 7'h01);
        16: pin("t16", 8'hEF, 7'h01);
        28: pin("t28", 8'h7F, 7'h01);
        32: pin("t32", 8'hFE, 7'h12);
        48: pin("t48", 8'hEF, 7'h01);
        64: pin("t64", 8'hFE, 7'h4C);
        default: ;
      endcase
    end

    // Fresh start, then reset mid-operation at t=50
    @(posedge clk); #2 rst = 1'b0;
    #1 pin("async_rst", 8'hFE, 7'h01);
    @(negedge clk); #1 rst = 1'b1;
    run_edges(50);
    @(posedge clk); #3 rst = 1'b0;
    #1 pin("mid_rst", 8'hFE, 7'h01);
    repeat (3) @(negedge clk);
    pin("mid_rst_hold", 8'hFE, 7'h01);
    #1 rst = 1'b1;
    run_edges(4);
    pin("restart_t4", 8'hFD, 7'h01);

    // Random run lengths with randomly timed async resets
    begin
      int total;
      total = 0;
      while (total < 10000) begin
        int n;
        n = int'($urandom_range(20, 1200));
        total += n;
        repeat (n) @(posedge clk);
        #($urandom_range(1, 4)) rst = 1'b0;
        #1 pin("rand_rst", 8'hFE, 7'h01);
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #($urandom_range(1, 4)) rst = 1'b1;
      end
      run_edges(200);
    end

    run_cmp = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hex_display_top.md
Name: hex_display_top

Overview:
- Board-level top block that keeps a free-running 32-bit event counter, a cycle-count style value from the CSR domain.
- Shows the counter value in hexadecimal on an 8-digit, time-multiplexed, common-anode seven-segment display.
- Sits at the FPGA pin boundary; its only I/O is clock, reset, digit-enable pins and segment pins.

Parameters:
- REFRESH_BITS, 2: each digit stays lit for 2^REFRESH_BITS cycles. Use 17 on the board, 2 in simulation.
- TICK_BITS, 4: the displayed value increments once every 2^TICK_BITS cycles.

Ports:
- clk  in  1  system clock, rising-edge active.
- rst  in  1  asynchronous, active-low reset (rst=0 resets).
- an  out  8  digit enables, active-low, exactly one bit low at all times; an[0] is the rightmost digit (nibble 0).
- a_to_g  out  7  segment drives, active-low; a_to_g[6]=a … a_to_g[0]=g.

Behaviour:
- Registers:
  - refresh_cnt, REFRESH_BITS+3 bits, wraps.
  - prescaler, TICK_BITS bits, wraps.
  - value, 32 bits.
- All three registers clear asynchronously while rst=0. Operation resumes on the first rising edge after rst returns to 1.
- Every cycle: refresh_cnt += 1 and prescaler += 1.
- When prescaler == all-ones: value += 1, mod 2^32, so 32'hFFFF_FFFF wraps to 0.
- Cycle relationship: after t rising edges out of reset,
  - refresh_cnt = t mod 2^(REFRESH_BITS+3)
  - value = floor(t / 2^TICK_BITS) mod 2^32
- Digit index idx = refresh_cnt[REFRESH_BITS+2 : REFRESH_BITS], 3 bits. Scans 0,1,…,7,0; full scan period is 8·2^REFRESH_BITS cycles.
- Outputs are combinational from registers only; no input-to-output path.
  - an = ~(8'b1 << idx)
  - a_to_g = seg(value[4·idx +: 4])
- Reset output values: an=8'hFE, a_to_g=7'h01.
- seg(), active-low abcdefg:
  - 0=01, 1=4F, 2=12, 3=06
  - 4=4C, 5=24, 6=20, 7=0F
  - 8=00, 9=04, A=08, b=60
  - C=31, d=42, E=30, F=38
- No leading-zero blanking and no decimal point; all 8 digits are always driven.
- Reset asserted mid-scan: outputs return to the reset values immediately, with no clock required.
- Latency: a value change appears on a_to_g the next time its digit is scanned.
- No glitch requirement beyond the outputs being registered-derived.

Decomposition:
- Package hex_display_pkg holds:
  - constants NUM_DIGITS=8 and SEG_W=7;
  - the 16-entry active-low segment constant table;
  - the digit-index type (3-bit logic).
- One sub-module, seg7_decoder: 4-bit nibble in, 7-bit active-low segments out, purely combinational. It is instantiated once and fed the selected nibble.

Test Plan (defaults REFRESH_BITS=2, TICK_BITS=4; t = rising edges after rst release):
1. Hold rst=0 for 4 cycles -> an=8'hFE, a_to_g=7'h01 throughout; pull rst low asynchronously between clock edges -> outputs take the reset values immediately.
2. t=4 -> an=8'hFD, a_to_g=7'h01. t=16 -> an=8'hEF, value=1, digit 4 shows 7'h01. t=28 -> an=8'h7F.
3. t=32 -> scan wraps, an=8'hFE, value=2, a_to_g=7'h12. t=48 -> value=3, but digit 0 is not shown again until t=64; at t=64 value=4, a_to_g=7'h4C.
4. Decoder sweep: drive seg7_decoder standalone with 0..F -> exactly the 16 codes in the seg() table.
5. Reset mid-operation at t=50 (rst low 3 cycles, then high) -> an=8'hFE, a_to_g=7'h01. Counting restarts from 0: 4 cycles after release, an=8'hFD.
6. Invariant check over 10,000 cycles -> an always has exactly one zero bit, and a_to_g always equals the table code of the nibble selected by the zero bit of an.
